// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressable data memory.
//   F3_*         : RISC-V funct3 access-size/sign encodings
//   dmem_state_t : controller states (CLEAR = post-reset zero sweep, READY = serving requests)
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    CLEAR,
    READY
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane handling for byte/halfword/word accesses.
// Ports:
//   we          : 1 = store, 0 = load
//   funct3      : RISC-V size/sign code
//   addr_lo     : byte offset within the word (addr[1:0])
//   wdata       : right-aligned store data
//   rword       : current contents of the addressed word
//   be          : byte enables for a store
//   wdata_lane  : store data replicated into its byte lanes
//   rdata_ext   : load result shifted to bit 0 and extended
//   misaligned  : halfword/word access not on its natural boundary
//   illegal     : funct3 not valid for this direction
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misaligned,
  output logic        illegal
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword[{addr_lo, 3'b000} +: 8];
  assign rhalf = rword[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    be         = '0;
    wdata_lane = '0;
    rdata_ext  = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_B: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{rbyte[7]}}, rbyte};
      end
      F3_H: begin
        misaligned = addr_lo[0];
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{rhalf[15]}}, rhalf};
      end
      F3_W: begin
        misaligned = |addr_lo;
        be         = '1;
        wdata_lane = wdata;
        rdata_ext  = rword;
      end
      // Unsigned sizes exist only for loads.
      F3_BU: begin
        illegal   = we;
        rdata_ext = {24'h000000, rbyte};
      end
      F3_HU: begin
        illegal    = we;
        misaligned = addr_lo[0];
        rdata_ext  = {16'h0000, rhalf};
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressable data memory with RISC-V load/store semantics and an
// optional zero sweep after reset.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   req_valid / req_ready    : request handshake (ready only in READY)
//   req_we, req_funct3       : store/load and access size/sign
//   req_addr, req_wdata      : byte address, right-aligned store data
//   rsp_valid, rsp_rdata     : one-cycle response pulse and load result
//   rsp_err                  : request rejected (range, alignment, funct3)
//   clear_busy               : zero sweep in progress
module byte_data_memory
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH          = 64,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        clear_busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  dmem_state_t   state, state_nxt;
  logic [AW-1:0] sweep_cnt;
  logic [AW-1:0] idx;
  logic          out_of_range;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wdata_lane;
  logic [31:0]   rdata_ext;
  logic          misaligned;
  logic          illegal;
  logic          accept;
  logic          err;

  assign idx          = req_addr[2 +: AW];
  assign out_of_range = |req_addr[31:2+AW];
  assign rword        = mem[idx];

  dmem_lane_align u_align (
    .we         (req_we),
    .funct3     (req_funct3),
    .addr_lo    (req_addr[1:0]),
    .wdata      (req_wdata),
    .rword      (rword),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  assign req_ready  = (state == READY);
  assign clear_busy = (state == CLEAR);
  assign accept     = req_valid && req_ready;
  assign err        = out_of_range || misaligned || illegal;

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && sweep_cnt == AW'(DEPTH - 1)) begin
      state_nxt = READY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR_ON_RESET ? CLEAR : READY;
      sweep_cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      if (state == CLEAR) begin
        sweep_cnt <= sweep_cnt + 1'b1;
      end
      rsp_valid <= accept;
      rsp_err   <= accept && err;
      rsp_rdata <= (accept && !req_we && !err) ? rdata_ext : '0;
    end
  end

  // Memory has no reset of its own; only the sweep zeroes it. Writes are
  // held off while reset is asserted so a restarted sweep begins cleanly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[sweep_cnt] <= '0;
      end else if (accept && req_we && !err) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (be[i]) begin
            mem[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_byte_data_memory.sv
module tb_byte_data_memory;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset, reset0;
  logic        req_valid, req_valid0;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err, clear_busy;
  logic [31:0] rsp_rdata;
  logic        req_ready0, rsp_valid0, rsp_err0, clear_busy0;
  logic [31:0] rsp_rdata0;

  always #5 clk = ~clk;

  byte_data_memory #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .clear_busy(clear_busy)
  );

  byte_data_memory #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b0)) dut0 (
    .clk(clk), .reset(reset0), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
    .rsp_err(rsp_err0), .clear_busy(clear_busy0)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] model [DEPTH*4];

  bit armed0 = 1'b0;
  int busy0_seen = 0;
  always @(negedge clk) if (armed0 && clear_busy0 === 1'b1) busy0_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < DEPTH*4; i++) model[i] = 8'h00;
  endtask

  // Reference: memory as a flat byte array, RISC-V rules applied directly.
  task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output logic err, output logic [31:0] rd);
    int unsigned nb;
    logic legal;
    logic [31:0] v;
    err = 1'b0;
    rd  = '0;
    case (f3)
      3'd0, 3'd4: nb = 1;
      3'd1, 3'd5: nb = 2;
      3'd2:       nb = 4;
      default:    nb = 0;
    endcase
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd5 && f3 != 3'd3);
    if (!legal) err = 1'b1;
    else if ((addr % nb) != 0) err = 1'b1;
    else if (addr >= DEPTH*4) err = 1'b1;
    else if (we) begin
      for (int i = 0; i < int'(nb); i++) model[addr + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < int'(nb); i++) v = v | (32'(model[addr + i]) << (8*i));
      if (f3[2] == 1'b0 && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3[2] == 1'b0 && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end
  endtask

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd);
    logic e;
    logic [31:0] d;
    model_req(we, f3, addr, wd, e, d);
    send(we, f3, addr, wd);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_err"},   32'(rsp_err),   32'(e));
    check({tag, "_rdata"}, rsp_rdata,      d);
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_sweep(input string tag, output int vseen);
    int n = 0;
    vseen = 0;
    while (clear_busy === 1'b1 && n < 200) begin
      if (rsp_valid === 1'b1) vseen++;
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd64);
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int vs;
    logic [31:0] a;
    reset = 1'b1; reset0 = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0;
    req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    @(negedge clk); @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_rsp_rdata", rsp_rdata,      32'd0);
    check("rst_clear_busy", 32'(clear_busy), 32'd1);
    check("rst_req_ready",  32'(req_ready),  32'd0);
    check("rst0_req_ready", 32'(req_ready0), 32'd1);
    check("rst0_clear_busy", 32'(clear_busy0), 32'd0);
    reset = 1'b0; reset0 = 1'b0; armed0 = 1'b1;
    wait_sweep("sweep0", vs);
    model_zero();

    // Fill with garbage, then reset and confirm the sweep wipes it.
    for (int w = 0; w < int'(DEPTH); w++) xact("garbage", 1'b1, F3_W, 32'(4*w), $urandom);
    idle();
    reset_pulse();
    check("rst2_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst2_req_ready", 32'(req_ready), 32'd0);
    wait_sweep("sweep1", vs);
    model_zero();
    xact("lw00", 1'b0, F3_W, 32'h00, '0);
    check("lw00_lit", rsp_rdata, 32'h0);
    xact("lwfc", 1'b0, F3_W, 32'hFC, '0);
    check("lwfc_lit", rsp_rdata, 32'h0);

    // Store / load lane handling.
    xact("sw20", 1'b1, F3_W, 32'h20, 32'hABCD_1234);
    xact("sb21", 1'b1, F3_B, 32'h21, 32'h0000_0080);
    xact("lw20", 1'b0, F3_W, 32'h20, '0);
    check("lw20_lit", rsp_rdata, 32'hABCD_8034);
    xact("lb21", 1'b0, F3_B, 32'h21, '0);
    check("lb21_lit", rsp_rdata, 32'hFFFF_FF80);
    xact("lbu21", 1'b0, F3_BU, 32'h21, '0);
    check("lbu21_lit", rsp_rdata, 32'h0000_0080);
    xact("lhu22", 1'b0, F3_HU, 32'h22, '0);
    check("lhu22_lit", rsp_rdata, 32'h0000_ABCD);

    // Rejected requests leave memory untouched.
    xact("sw10", 1'b1, F3_W, 32'h10, 32'h1122_3344);
    xact("lw22_mis", 1'b0, F3_W, 32'h22, '0);
    check("lw22_err_lit", 32'(rsp_err), 32'd1);
    xact("sh13_mis", 1'b1, F3_H, 32'h13, 32'hFFFF_FFFF);
    check("sh13_err_lit", 32'(rsp_err), 32'd1);
    xact("lw100_oor", 1'b0, F3_W, 32'h100, '0);
    check("lw100_err_lit", 32'(rsp_err), 32'd1);
    xact("sbu_illegal", 1'b1, F3_BU, 32'h10, 32'hFFFF_FFFF);
    xact("ld3_illegal", 1'b0, 3'b011, 32'h10, '0);
    xact("lw10", 1'b0, F3_W, 32'h10, '0);
    check("lw10_lit", rsp_rdata, 32'h1122_3344);
    idle();

    // Back-to-back store then load of the same word.
    @(negedge clk);
    xact("b2b_sw", 1'b1, F3_W, 32'h40, 32'h5678_9ABC);
    xact("b2b_lw", 1'b0, F3_W, 32'h40, '0);
    check("b2b_lw_lit", rsp_rdata, 32'h5678_9ABC);
    idle();
    @(negedge clk);
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);

    // Reset in the middle of a sweep restarts it from word 0.
    reset_pulse();
    repeat (29) @(negedge clk);
    check("midsweep_busy", 32'(clear_busy), 32'd1);
    reset_pulse();
    wait_sweep("sweep_restart", vs);
    model_zero();

    // Reset right after a load acceptance drops the response stream.
    send(1'b0, F3_W, 32'h20, '0);
    check("preRst_valid", 32'(rsp_valid), 32'd1);
    idle();
    reset_pulse();
    check("postRst_valid", 32'(rsp_valid), 32'd0);
    check("postRst_rdata", rsp_rdata, 32'd0);
    wait_sweep("sweep_after_load", vs);
    check("postRst_no_valid", 32'(vs), 32'd0);
    model_zero();

    // Instance without the sweep.
    reset0 = 1'b1;
    @(posedge clk); @(negedge clk);
    reset0 = 1'b0;
    check("cor0_ready", 32'(req_ready0), 32'd1);
    check("cor0_busy",  32'(clear_busy0), 32'd0);
    req_valid0 = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h8; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); @(negedge clk);
    req_we = 1'b0;
    @(posedge clk); @(negedge clk);
    req_valid0 = 1'b0;
    check("cor0_lw_valid", 32'(rsp_valid0), 32'd1);
    check("cor0_lw_rdata", rsp_rdata0, 32'hCAFE_F00D);

    // Random traffic, continuous valid.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = 32'($urandom_range(0, DEPTH*4 + 7));
      xact("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end
    idle();
    @(negedge clk);
    check("rand_idle_valid", 32'(rsp_valid), 32'd0);
    check("cor0_never_busy", 32'(busy0_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_data_memory.md
BYTE_DATA_MEMORY -- requirements
Module: byte_data_memory

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words; it is a power of two and at least 4.
REQ-002 The block SHALL have parameter CLEAR_ON_RESET, default 1, meaning: 1 = sweep memory to zero after reset; 0 = skip the sweep.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: a request is present.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_funct3, input, 3 bits: RISC-V access size and sign. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
REQ-009 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: response pulse with no back-pressure.
REQ-012 The block SHALL have port rsp_rdata, output, 32 bits: load result, already extended.
REQ-013 The block SHALL have port rsp_err, output, 1 bit: the request was rejected.
REQ-014 The block SHALL have port clear_busy, output, 1 bit: the post-reset sweep is in progress.

Function
REQ-015 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-016 req_ready SHALL be 1 exactly in state READY; it does not depend on req_valid.
REQ-017 State machine:
- States are CLEAR and READY.
- reset moves the FSM to CLEAR when CLEAR_ON_RESET=1, otherwise to READY.
- CLEAR moves to READY after the cycle that writes word DEPTH-1.
REQ-018 In CLEAR, the block SHALL write zero to one word per cycle, with an index counter ($clog2(DEPTH) bits) running from 0 to DEPTH-1; the sweep takes exactly DEPTH cycles.
REQ-019 Word index SHALL be req_addr[2+:$clog2(DEPTH)].
- The access is out-of-range if any req_addr bit above that index field is nonzero.
- Out-of-range accesses are rejected; the address does not wrap.
REQ-020 Alignment SHALL be checked as follows; any violation is a misaligned access:
- Halfword accesses need req_addr[0]=0.
- Word accesses need req_addr[1:0]=00.
- Byte accesses are always aligned.
REQ-021 An illegal funct3 SHALL be rejected: loads 011/110/111, stores 011–111.
REQ-022 A rejected request SHALL:
- leave memory unchanged;
- produce rsp_valid=1, rsp_err=1, rsp_rdata=0 one cycle after acceptance.
REQ-023 A store SHALL write only the bytes it selects, on the acceptance edge:
- SB writes byte lane addr[1:0] with wdata[7:0].
- SH writes lanes addr[1]*2+{0,1} with wdata[15:0].
- SW writes all four lanes.
REQ-024 A store response SHALL be rsp_valid=1, rsp_err=0, rsp_rdata=0, one cycle after acceptance.
REQ-025 A load SHALL have 1-cycle latency: rsp_valid=1 and rsp_rdata on the edge after acceptance. The selected byte or halfword is shifted to bit 0, sign-extended for LB/LH and zero-extended for LBU/LHU.
REQ-026 Back-to-back requests SHALL be accepted every cycle in READY, with one response per cycle.
REQ-027 A load accepted the cycle after a store to the same word SHALL return the post-store data.
REQ-028 rsp_valid SHALL be 0 in any cycle not preceded by an acceptance.

Reset
REQ-029 reset SHALL force all of the following on the next edge, regardless of state:
- rsp_valid=0, rsp_err=0, rsp_rdata=0;
- sweep counter = 0;
- clear_busy=CLEAR_ON_RESET, req_ready=!CLEAR_ON_RESET.
REQ-030 A response pending when reset is asserted SHALL be dropped, and a sweep in progress SHALL restart from word 0.
REQ-031 Memory contents SHALL NOT be cleared by reset itself, only by the sweep.

Structure
REQ-032 Package dmem_pkg SHALL hold:
- the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
- the state enum dmem_state_t {CLEAR, READY}.
REQ-033 Sub-module dmem_lane_align SHALL do the combinational work: byte-enable and store-data lane placement, load lane extraction and extension, and the misalignment/illegal-funct3 checks.
REQ-034 The memory array, FSM, sweep counter and response registers SHALL reside in byte_data_memory.

Verification
REQ-035 Sweep test: pre-load garbage, apply reset 1 cycle, DEPTH=64, CLEAR_ON_RESET=1.
- clear_busy is high for exactly 64 cycles.
- req_ready then rises.
- LW addr 0x00 and LW addr 0xFC both return 0x00000000.
REQ-036 Store/load test: SW 0xABCD1234 @0x20, then SB 0x80 @0x21. Loads from 0x20 must return:
- LW 0xABCD8034;
- LB @0x21 0xFFFFFF80;
- LBU @0x21 0x00000080;
- LHU @0x22 0x0000ABCD.
REQ-037 Error test:
- LW @0x22, SH @0x13 and LW @0x100 (DEPTH=64) each respond with rsp_err=1 and rdata 0.
- A following LW @0x10 shows the word unchanged.
REQ-038 Back-to-back test: SW 0x5678_9ABC @0x40, then LW @0x40 the next cycle.
- rsp_valid is high for 2 consecutive cycles.
- The second response is 0x56789ABC.
REQ-039 Reset-mid-operation test:
- Assert reset during cycle 30 of the sweep: clear_busy stays high for 64 more cycles.
- Assert reset the cycle after a load acceptance: no rsp_valid follows.
REQ-040 CLEAR_ON_RESET=0 test: req_ready=1 on the first cycle after reset and clear_busy is never asserted.
